// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, constants and fetch state encoding
package fetch_unit_pkg;
  localparam int PC_W = 10;
  localparam int INSTR_W = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [5:0] HALT_OPCODE = 6'h3F;
  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program counter register with redirect / hold / increment mux
module fetch_pc_gen #(
  parameter int PC_W = fetch_unit_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o
);
  logic [PC_W-1:0] pc_q, pc_d;
  // next pc: redirect beats increment, otherwise hold; increment wraps naturally
  always_comb pc_d = redirect_i ? target_i : advance_i ? pc_q + 1'b1 : pc_q;
  // pc register, synchronous active-low reset
  always_ff @(posedge clk)
    if (!reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with pc, IF/ID register, halt detection; FETCH_PERF_COUNT_EN adds fetch/bubble counters
module fetch_unit #(
  parameter int PC_W = fetch_unit_pkg::PC_W,
  parameter int INSTR_W = fetch_unit_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        bubble_count
`endif
);
  import fetch_unit_pkg::*;
  fetch_state_e state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0] ipc_q, pc;
  logic valid_q, advance, load_pc, load_fetch, load_bubble, is_halt;
  fetch_pc_gen #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .redirect_i(load_pc), .target_i(redirect_target),
    .advance_i(advance), .pc_o(pc)
  );
  assign is_halt = rom_data[INSTR_W-1 -: 6] == HALT_OPCODE;
  // fetch FSM: decides pc movement and what the IF/ID register loads
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    load_pc = 1'b0;
    load_fetch = 1'b0;
    load_bubble = 1'b0;
    case (state_q)
      FETCH_BOOT: begin
        state_d = FETCH_RUN;
        load_pc = redirect;
      end
      FETCH_RUN:
        if (redirect) begin
          load_pc = 1'b1;
          load_bubble = 1'b1;
        end else if (!stall) begin
          load_fetch = 1'b1;
          advance = 1'b1;
          state_d = is_halt ? FETCH_HALT : FETCH_RUN;
        end
      FETCH_HALT:
        if (redirect) begin
          load_pc = 1'b1;
          load_bubble = 1'b1;
          state_d = FETCH_RUN;
        end else load_bubble = !stall;
      default: state_d = FETCH_BOOT;
    endcase
  end
  // state and IF/ID pipeline register; a bubble keeps the stale pc
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= FETCH_BOOT;
      instr_q <= NOP_INSTR;
      ipc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_fetch) begin
        instr_q <= rom_data;
        ipc_q <= pc;
        valid_q <= 1'b1;
      end else if (load_bubble) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  assign rom_addr = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc = ipc_q;
  assign if_id_valid = valid_q;
  assign halted = state_q == FETCH_HALT;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetch_q, bubble_q;
  // saturating performance counters
  always_ff @(posedge clk)
    if (!reset) begin
      fetch_q <= '0;
      bubble_q <= '0;
    end else begin
      if (load_fetch && fetch_q != 16'hFFFF) fetch_q <= fetch_q + 1'b1;
      if (load_bubble && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 1'b1;
    end
  assign fetch_count = fetch_q;
  assign bubble_count = bubble_q;
`endif
endmodule
